// File: rtl/hilo_pkg.sv
// hilo_unit shared definitions: op codes, FSM states, default width.
package hilo_pkg;

    localparam int DEF_DATA_W = 32;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_MULT = 3'd1;
    localparam logic [2:0] OP_MTHI = 3'd2;
    localparam logic [2:0] OP_MTLO = 3'd3;
    localparam logic [2:0] OP_MFHI = 3'd4;
    localparam logic [2:0] OP_MFLO = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    function automatic logic is_hilo_op(input logic [2:0] code);
        return (code >= OP_MULT) && (code <= OP_MFLO);
    endfunction

endpackage

// File: rtl/hilo_if.sv
// Decode-side operation bus into the HI/LO unit.
interface hilo_if
    import hilo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              op_valid;
    logic [2:0]        op_code;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] rd_val;
    logic              stall;

    modport master (
        output op_valid, op_code, rs_val, rt_val,
        input  rd_val, stall
    );

    modport slave (
        input  op_valid, op_code, rs_val, rt_val,
        output rd_val, stall
    );

endinterface

// File: rtl/hilo_unit.sv
// HI/LO register owner: launches the multiplier and captures its result.
// Define HILO_FWD_EN to let MFHI/MFLO read the product in the capture cycle.
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MUL_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    hilo_if.slave             op,
    output logic              mul_start,
    output logic [DATA_W-1:0] mul_a,
    output logic [DATA_W-1:0] mul_b,
    input  logic [DATA_W-1:0] mul_hi,
    input  logic [DATA_W-1:0] mul_lo,
    output logic              busy,
    output logic [DATA_W-1:0] hi_q,
    output logic [DATA_W-1:0] lo_q
);

    localparam int CNT_W = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] hi_d, lo_d;
    logic [DATA_W-1:0] mul_a_d, mul_b_d;
    logic              mul_start_d;

    logic is_op;
    logic is_rd;
    logic capture;
    logic fwd_ok;
    logic accept;

    assign is_op   = op.op_valid & is_hilo_op(op.op_code);
    assign is_rd   = op.op_valid &
                     ((op.op_code == OP_MFHI) | (op.op_code == OP_MFLO));
    assign busy    = (state_q == ST_BUSY);
    assign capture = busy & (cnt_q == '0);

`ifdef HILO_FWD_EN
    assign fwd_ok = capture & is_rd;
`else
    assign fwd_ok = 1'b0;
`endif

    assign op.stall = is_op & busy & ~fwd_ok;
    assign accept   = op.op_valid & ~op.stall;

    // Reads in the capture cycle (forwarding only) take the live product.
    always_comb begin
        op.rd_val = '0;
        if (accept) begin
            case (op.op_code)
                OP_MFHI: op.rd_val = fwd_ok ? mul_hi : hi_q;
                OP_MFLO: op.rd_val = fwd_ok ? mul_lo : lo_q;
                default: op.rd_val = '0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        mul_a_d     = mul_a;
        mul_b_d     = mul_b;
        mul_start_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (op.op_code)
                        OP_MULT: begin
                            mul_a_d     = op.rs_val;
                            mul_b_d     = op.rt_val;
                            mul_start_d = 1'b1;
                            cnt_d       = CNT_W'(MUL_LAT);
                            state_d     = ST_BUSY;
                        end
                        OP_MTHI: hi_d = op.rs_val;
                        OP_MTLO: lo_d = op.rs_val;
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                if (capture) begin
                    hi_d    = mul_hi;
                    lo_d    = mul_lo;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_start <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mul_a     <= mul_a_d;
            mul_b     <= mul_b_d;
            mul_start <= mul_start_d;
        end
    end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Sits directly downstream of the signed multiplier. Owns the architectural HI/LO registers of the 54-instruction CPU.
- Accepts MULT / MTHI / MTLO / MFHI / MFLO from decode, launches the multiplier with a one-cycle start pulse, and captures its HI/LO result after a fixed latency.
- Stalls the pipeline on any HI/LO access while a multiply is in flight.

Parameters:
- DATA_W, 32: operand and HI/LO width.
- MUL_LAT, 1: number of clock edges from the multiplier sampling mul_start to mul_hi/mul_lo being valid. Must be at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op_valid  in  1  decode presents an operation this cycle.
- op_code  in  3  0=NOP, 1=MULT, 2=MTHI, 3=MTLO, 4=MFHI, 5=MFLO; 6 and 7 are treated as NOP.
- rs_val  in  DATA_W  first operand; also the MTHI/MTLO data.
- rt_val  in  DATA_W  second operand.
- mul_start  out  1  drives the multiplier ctr input.
- mul_a  out  DATA_W  registered operand to the multiplier.
- mul_b  out  DATA_W  registered operand to the multiplier.
- mul_hi  in  DATA_W  product upper word from the multiplier.
- mul_lo  in  DATA_W  product lower word from the multiplier.
- rd_val  out  DATA_W  MFHI/MFLO read data (combinational).
- stall  out  1  operation not accepted; upstream holds op_code and operands.
- busy  out  1  multiply in flight.
- hi_q  out  DATA_W  architectural HI.
- lo_q  out  DATA_W  architectural LO.

Behaviour:
- Reset (asynchronous, active-low):
  - hi_q, lo_q, mul_a, mul_b reset to 0; mul_start, busy, stall reset to 0; state goes to IDLE.
  - Asserting reset during BUSY discards the in-flight product; no capture occurs after release.
- States: IDLE, BUSY.
  - Down-counter cnt, width clog2(MUL_LAT+1).
- IDLE:
  - MULT accepted at edge E0: mul_a<=rs_val, mul_b<=rt_val, mul_start<=1 for exactly one cycle, cnt<=MUL_LAT, state goes to BUSY.
  - MTHI at edge: hi_q<=rs_val. MTLO at edge: lo_q<=rs_val. The other register is untouched.
  - MFHI: rd_val=hi_q in the same cycle. MFLO: rd_val=lo_q in the same cycle.
  - A value written by MTHI/MTLO is readable from the next cycle.
- BUSY:
  - The multiplier samples mul_start at edge E1.
  - cnt decrements at each edge from E1 onward.
  - Capture cycle is the cycle with cnt==0. At its closing edge E(1+MUL_LAT): hi_q<=mul_hi, lo_q<=mul_lo, state goes to IDLE.
  - busy=1 in every BUSY cycle, i.e. 1+MUL_LAT cycles.
- Stall:
  - stall = op_valid & busy & (op_code is in 1..5). Combinational.
  - A stalled operation has no side effect and is re-presented by upstream. It is accepted in the first IDLE cycle.
  - NOP, codes 6/7, and op_valid=0 never stall.
- rd_val is 0 unless an accepted MFHI/MFLO is present.
- Multiply semantics, signedness and the 64-bit split belong to the multiplier. This block transfers words only.
- MULT in IDLE with simultaneous older writeback cannot occur, because capture always exits BUSY first.

Optional Feature:
- Macro: HILO_FWD_EN.
- Defined: in the capture cycle, MFHI/MFLO do not stall. rd_val=mul_hi or mul_lo directly. MTHI/MTLO/MULT still stall in that cycle.
- Undefined: every access during BUSY stalls, including the capture cycle.

Decomposition:
- Shared package hilo_pkg: op_code localparams (OP_NOP, OP_MULT, OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO), state encoding (ST_IDLE, ST_BUSY), DATA_W default.
- No sub-module: state machine, counter and registers are one module. The multiplier is instantiated alongside by the datapath top, not inside this block.

Test Plan (MUL_LAT=1, bench multiplier model registers a*b signed on ctr):
- Release reset -> hi_q=lo_q=0, busy=0, stall=0, mul_start=0, rd_val=0.
- MULT rs=0xFFFFFFFE, rt=0x00000003:
  - mul_start high for exactly 1 cycle, mul_a=0xFFFFFFFE, busy high for 2 cycles.
  - Then hi_q=0xFFFFFFFF, lo_q=0xFFFFFFFA.
- MFLO presented the cycle after MULT:
  - Without HILO_FWD_EN: stall=1 for 2 cycles, then rd_val=0xFFFFFFFA.
  - With HILO_FWD_EN: stall=1 for 1 cycle, then rd_val=0xFFFFFFFA from mul_lo.
- MTHI rs=0x12345678, then MFHI -> rd_val=0x12345678; lo_q unchanged from its prior value.
- MULT 7*6, reset pulsed low during BUSY, reset released -> hi_q=lo_q=0, busy=0, no later capture.
- Back-to-back MULT with 2*3 then 4*5 -> second stalls until IDLE; final hi_q=0, lo_q=0x00000014.
